truth_table_engine: RTL
=======================

TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 Parameter N_IN, default 3: number of logic inputs, legal range 1..6.
REQ-002 Parameter RESET_TABLE, default 8'hA5, width 2**N_IN: truth table loaded at reset; bit i = output for input index i.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  evaluation request present.
REQ-006 in_ready  output  1  engine can accept a request this cycle.
REQ-007 in_data  input  N_IN  input vector; MSB = in1, LSB = in(N_IN); value forms table index.
REQ-008 out_valid  output  1  out_bit holds an unconsumed result.
REQ-009 out_ready  input  1  downstream consumes result this cycle.
REQ-010 out_bit  output  1  registered table lookup result.
REQ-011 cfg_start  input  1  single-cycle pulse; begins a new table load.
REQ-012 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-013 cfg_bit  input  1  serial table bit, index 0 first.
REQ-014 cfg_busy  output  1  load in progress.
REQ-015 active_table  output  2**N_IN  currently applied truth table.

Function
REQ-016 Request accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-017 On acceptance, out_bit <= active_table[in_data] and out_valid <= 1 on the next edge; latency exactly 1 cycle.
REQ-018 out_valid clears when out_valid && out_ready && no new acceptance in the same cycle.
REQ-019 out_bit and out_valid hold stable while out_valid && !out_ready.
REQ-020 Back-to-back acceptance with out_ready held high sustains one result per cycle.
REQ-021 Load FSM states IDLE, LOAD: IDLE->LOAD on cfg_start; LOAD->IDLE after 2**N_IN bits accepted; cfg_busy = (state == LOAD).
REQ-022 cfg_start clears the bit counter and shadow table; cfg_valid in IDLE is ignored.
REQ-023 In LOAD, each cfg_valid writes cfg_bit to shadow[count] and increments count (width clog2(2**N_IN)+1).
REQ-024 On the edge accepting the final bit, active_table <= complete shadow; partial shadow never reaches active_table.
REQ-025 Evaluation continues during LOAD using the old active_table; a request accepted on the swap edge uses the old table.
REQ-026 cfg_start in LOAD (including the final-bit cycle) restarts the load; partial data discarded, active_table unchanged.

Reset
REQ-027 rst SHALL set: active_table = RESET_TABLE, shadow = 0, count = 0, state IDLE, cfg_busy = 0, out_valid = 0, out_bit = 0.
REQ-028 rst overrides every other input in the same cycle; a load or pending result in progress is discarded.

Configuration
REQ-029 Macro TRUTH_TABLE_ENGINE_EVAL_COUNT_EN: when defined, adds output eval_count (16 bits) counting accepted requests; reset to 0; wraps 16'hFFFF->0.
REQ-030 Without TRUTH_TABLE_ENGINE_EVAL_COUNT_EN, port eval_count and its counter are absent; all other behaviour identical.

Verification
REQ-031 After rst, N_IN=3, out_ready=1, sweep in_data 0..7 -> out_bit sequence 1,0,1,0,0,1,0,1, each 1 cycle after acceptance.
REQ-032 cfg_start, then 8 bits of 8'h96 (LSB first) -> cfg_busy high 8+ cycles, active_table = 8'h96; in_data 3'b011 -> out_bit 0, 3'b001 -> out_bit 1.
REQ-033 Request on the final-bit edge while loading 8'h00 over 8'hFF -> that result = 1; next request -> 0.
REQ-034 out_ready low 5 cycles with out_valid=1 -> in_ready=0, out_bit stable; out_ready high -> one transfer, then pipeline resumes.
REQ-035 cfg_start after 4 bits, then 8 bits of 8'h0F -> active_table = 8'h0F, never a partial value; rst mid-load -> active_table = 8'hA5, cfg_busy = 0.
REQ-036 With TRUTH_TABLE_ENGINE_EVAL_COUNT_EN, 65537 accepted requests -> eval_count = 1.

Source files
------------

// File: rtl/truth_table_engine.sv
// truth_table_engine
//   Registered truth-table lookup with a serially reloadable table.
//   Evaluation path: a one-deep valid/ready output register. An accepted
//   request (in_valid && in_ready) returns active_table[in_data] on out_bit
//   one cycle later.
//   Load path: cfg_start opens a load. Each cfg_valid in LOAD shifts one bit
//   (index 0 first) into a shadow table. The complete shadow replaces
//   active_table atomically on the edge that accepts the final bit.
//   Optional macro TRUTH_TABLE_ENGINE_EVAL_COUNT_EN adds a 16-bit wrapping
//   counter of accepted requests on port eval_count.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data      evaluation request handshake
//   out_valid/out_ready/out_bit    result handshake
//   cfg_start/cfg_valid/cfg_bit    serial table load
//   cfg_busy                       load in progress
//   eval_count                     accepted-request count (macro only)
//   active_table                   table currently used for lookups
module truth_table_engine #(
    parameter int N_IN = 3,
    parameter logic [2**N_IN-1:0] RESET_TABLE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_busy,
`ifdef TRUTH_TABLE_ENGINE_EVAL_COUNT_EN
    output logic [15:0]          eval_count,
`endif
    output logic [2**N_IN-1:0]   active_table
);
    localparam int TW = 2**N_IN;
    localparam int CW = N_IN + 1;
    localparam logic [CW-1:0] LAST = CW'(TW - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [TW-1:0]   shadow;
    logic [TW-1:0]   shadow_nx;
    logic            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cfg_busy = (state == LOAD);

    // Shadow with the incoming bit merged in; used both for the running
    // shadow and for the atomic swap on the final bit.
    always_comb begin
        shadow_nx = shadow;
        shadow_nx[count[N_IN-1:0]] = cfg_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_bit      <= 1'b0;
            state        <= IDLE;
            count        <= '0;
            shadow       <= '0;
            active_table <= RESET_TABLE;
        end else begin
            // Lookup uses the pre-edge table, so a request on the swap
            // edge still sees the old contents.
            if (accept) begin
                out_bit   <= active_table[in_data];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state  <= LOAD;
                        count  <= '0;
                        shadow <= '0;
                    end
                end
                LOAD: begin
                    // A restart wins even over the final bit: the partial
                    // data is dropped and active_table is left alone.
                    if (cfg_start) begin
                        count  <= '0;
                        shadow <= '0;
                    end else if (cfg_valid) begin
                        shadow <= shadow_nx;
                        count  <= count + 1'b1;
                        if (count == LAST) begin
                            active_table <= shadow_nx;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRUTH_TABLE_ENGINE_EVAL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            eval_count <= '0;
        else if (accept)
            eval_count <= eval_count + 16'd1;
    end
`endif

endmodule
